// File: rtl/iic_defs.sv
// Shared I2C target definitions: FSM state encoding and default addressing,
// also used by host-side software models.
package iic_defs;

  localparam logic [6:0] IIC_DEF_DEV_ADDR = 7'h29;
  localparam logic [7:0] IIC_DEF_WR_BYTE  = {IIC_DEF_DEV_ADDR, 1'b0};
  localparam logic [7:0] IIC_DEF_RD_BYTE  = {IIC_DEF_DEV_ADDR, 1'b1};

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_REG_ADDR,
    ST_REG_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } iic_state_e;

endpackage

// File: rtl/iic_bus_sync.sv
// Synchronizes raw scl/sda into clk and derives scl edge and START/STOP strobes.
module iic_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;

  // Chains reset to the idle-bus level so a reset never fakes an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= SYNC_STAGES'({scl_sync_q, scl_i});
      sda_sync_q <= SYNC_STAGES'({sda_sync_q, sda_i});
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/iic_target.sv
// I2C register-file target: byte writes to wr_* and byte reads via rd_req/rd_data.
//
//  state     | meaning
//  IDLE      | bus free, waiting for START
//  DEV_ADDR  | shifting in address byte
//  DEV_ACK   | driving ACK for our address
//  REG_ADDR  | shifting in register pointer
//  REG_ACK   | driving ACK for pointer
//  WR_DATA   | shifting in write data
//  WR_ACK    | driving ACK for write data
//  RD_DATA   | driving read byte, MSB first
//  RD_ACK    | SDA released, sampling master ACK/NACK
//  IGNORE    | not addressed or NACKed, wait for START/STOP
module iic_target
  import iic_defs::*;
#(
  parameter logic [6:0] DEV_ADDR    = IIC_DEF_DEV_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_req,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  iic_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl),
    .sda_i     (sda_i),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start_det),
    .stop_o    (stop_det)
  );

  iic_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, ptr_q, ptr_d;
  logic [7:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d, rd_addr_q, rd_addr_d;
  logic       rw_q, rw_d, ack_q, ack_d, load_q, load_d;
  logic       oe_q, oe_d, wr_en_q, wr_en_d, rd_req_q, rd_req_d, busy_q, busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
      rw_q      <= 1'b0;
      ack_q     <= 1'b0;
      load_q    <= 1'b0;
      oe_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_req_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_addr_q <= rd_addr_d;
      rw_q      <= rw_d;
      ack_q     <= ack_d;
      load_q    <= load_d;
      oe_q      <= oe_d;
      wr_en_q   <= wr_en_d;
      rd_req_q  <= rd_req_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_addr_d = rd_addr_q;
    rw_d      = rw_q;
    ack_d     = ack_q;
    load_d    = rd_req_q;
    oe_d      = oe_q;
    wr_en_d   = 1'b0;
    rd_req_d  = 1'b0;
    busy_d    = busy_q;

    if (stop_det) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      load_d  = 1'b0;
    end else if (start_det) begin
      state_d = ST_DEV_ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b1;
      load_d  = 1'b0;
    end else begin
      // First read bit can only be driven once rd_data is latched, a few clk into SCL low.
      if (load_q && state_q == ST_RD_DATA) begin
        shift_d = rd_data;
        oe_d    = ~rd_data[7];
      end

      if (scl_rise) begin
        unique case (state_q)
          ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end
          ST_RD_DATA: cnt_d = cnt_q + 4'd1;
          ST_RD_ACK:  ack_d = ~sda_s;
          default: ;
        endcase
      end

      if (scl_fall) begin
        unique case (state_q)
          ST_DEV_ADDR: if (cnt_q == 4'd8) begin
            cnt_d = '0;
            if (shift_q[7:1] == DEV_ADDR) begin
              state_d = ST_DEV_ACK;
              rw_d    = shift_q[0];
              oe_d    = 1'b1;
            end else begin
              state_d = ST_IGNORE;
            end
          end
          ST_DEV_ACK: if (rw_q) begin
            state_d   = ST_RD_DATA;
            rd_req_d  = 1'b1;
            rd_addr_d = ptr_q;
          end else begin
            state_d = ST_REG_ADDR;
            oe_d    = 1'b0;
          end
          ST_REG_ADDR: if (cnt_q == 4'd8) begin
            state_d = ST_REG_ACK;
            cnt_d   = '0;
            ptr_d   = shift_q;
            oe_d    = 1'b1;
          end
          ST_REG_ACK, ST_WR_ACK: begin
            state_d = ST_WR_DATA;
            oe_d    = 1'b0;
          end
          ST_WR_DATA: if (cnt_q == 4'd8) begin
            state_d   = ST_WR_ACK;
            cnt_d     = '0;
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = shift_q;
            ptr_d     = ptr_q + 8'd1;
            oe_d      = 1'b1;
          end
          ST_RD_DATA: if (cnt_q == 4'd8) begin
            state_d = ST_RD_ACK;
            cnt_d   = '0;
            ptr_d   = ptr_q + 8'd1;
            oe_d    = 1'b0;
          end else begin
            shift_d = {shift_q[6:0], 1'b0};
            oe_d    = ~shift_q[6];
          end
          ST_RD_ACK: if (ack_q) begin
            state_d   = ST_RD_DATA;
            rd_req_d  = 1'b1;
            rd_addr_d = ptr_q;
          end else begin
            state_d = ST_IGNORE;
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe  = oe_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_req  = rd_req_q;
  assign rd_addr = rd_addr_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_iic_target.sv
// Bench for iic_target: bit-banged I2C master, open-drain bus, memory responder
// and a transaction-level pointer/memory model.
module tb_iic_target;
  import iic_defs::*;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_i, sda_oe, wr_en, rd_req, busy;
  logic [7:0] wr_addr, wr_data, rd_addr;
  logic [7:0] rd_data = 8'h00;

  int tests = 0;
  int fails = 0;

  logic [7:0]  mem [256];
  logic [15:0] wq [$];
  logic [7:0]  rq [$];
  logic [7:0]  dq [$];
  logic [7:0]  mptr;
  int          oe_hi = 0;

  always #10 clk = ~clk;
  assign sda_i = m_sda & ~sda_oe;

  iic_target #(.DEV_ADDR(7'h29), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda_i(sda_i), .sda_oe(sda_oe),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  always @(posedge clk) begin
    if (rd_req) begin
      rd_data <= mem[rd_addr];
      rq.push_back(rd_addr);
    end
    if (wr_en) wq.push_back({wr_addr, wr_data});
    if (sda_oe) oe_hi <= oe_hi + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wclk(Q);
    scl = 1'b1;   wclk(Q);
    m_sda = 1'b0; wclk(Q);
    scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wclk(Q); m_sda = 1'b0; wclk(Q);
    scl = 1'b1; wclk(Q);
    m_sda = 1'b1; wclk(Q);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      wclk(Q); m_sda = b[i];
      wclk(Q); scl = 1'b1;
      wclk(2*Q); scl = 1'b0;
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    wclk(Q); m_sda = 1'b1;
    wclk(Q); scl = 1'b1;
    wclk(Q); ack = (sda_oe === 1'b1) && (sda_i === 1'b0);
    wclk(Q); scl = 1'b0;
  endtask

  task automatic read_byte(input bit give_ack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      wclk(Q); m_sda = 1'b1;
      wclk(Q); scl = 1'b1;
      wclk(Q); d[i] = sda_i;
      wclk(Q); scl = 1'b0;
    end
    wclk(Q); m_sda = give_ack ? 1'b0 : 1'b1;
    wclk(Q); scl = 1'b1;
    wclk(2*Q); scl = 1'b0;
  endtask

  // Writes the bytes queued in dq starting at reg_a and checks the resulting wr_en stream.
  task automatic master_write(input logic [7:0] reg_a);
    logic ack;
    logic [31:0] got;
    i2c_start();
    write_byte(8'h52, ack); check("w_dev_ack", ack, 1);
    check("w_busy", busy, 1);
    write_byte(reg_a, ack); check("w_reg_ack", ack, 1);
    foreach (dq[i]) begin
      write_byte(dq[i], ack); check("w_data_ack", ack, 1);
    end
    i2c_stop();
    check("w_busy_after_stop", busy, 0);
    check("w_count", wq.size(), dq.size());
    foreach (dq[i]) begin
      got = (wq.size() > 0) ? {16'h0, wq.pop_front()} : 32'hDEAD_0000;
      check("w_entry", got, {16'h0, reg_a + 8'(i), dq[i]});
    end
    check("w_no_rd_req", rq.size(), 0);
    mptr = reg_a + 8'(dq.size());
  endtask

  task automatic master_read(input bit set_reg, input logic [7:0] reg_a, input int n);
    logic ack;
    logic [7:0] d;
    logic [31:0] got;
    i2c_start();
    if (set_reg) begin
      write_byte(8'h52, ack); check("r_wdev_ack", ack, 1);
      write_byte(reg_a, ack); check("r_reg_ack", ack, 1);
      mptr = reg_a;
      i2c_start();
    end
    write_byte(8'h53, ack); check("r_dev_ack", ack, 1);
    for (int i = 0; i < n; i++) begin
      read_byte(i < n - 1, d);
      check("r_data", d, mem[mptr + 8'(i)]);
    end
    check("r_release_after_nack", sda_oe, 0);
    i2c_stop();
    check("r_busy_after_stop", busy, 0);
    check("r_req_count", rq.size(), n);
    for (int i = 0; i < n; i++) begin
      got = (rq.size() > 0) ? {24'h0, rq.pop_front()} : 32'hDEAD_0000;
      check("r_addr", got, {24'h0, mptr + 8'(i)});
    end
    check("r_no_wr_en", wq.size(), 0);
    mptr = mptr + 8'(n);
  endtask

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack;
    logic [7:0] d;
    int oe0, kind, n, waited;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mptr = 8'h00;

    wclk(5);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_req", rd_req, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rd_addr", rd_addr, 0);
    rst = 1'b0;
    wclk(5);

    dq = {8'hA5};
    master_write(8'h36);
    dq = {8'h11, 8'h22};
    master_write(8'h36);

    oe0 = oe_hi;
    i2c_start();
    write_byte(8'h54, ack); check("foreign_addr_ack", ack, 0);
    write_byte(8'h36, ack); check("foreign_data_ack", ack, 0);
    i2c_stop();
    check("foreign_oe_never", oe_hi - oe0, 0);
    check("foreign_wr_en", wq.size(), 0);
    check("foreign_rd_req", rq.size(), 0);

    mem[8'h10] = 8'h5C;
    mem[8'h11] = 8'hC3;
    master_read(1'b1, 8'h10, 2);

    i2c_start();
    write_byte(8'h52, ack); check("part_dev_ack", ack, 1);
    write_byte(8'h40, ack); check("part_reg_ack", ack, 1);
    mptr = 8'h40;
    send_bits(8'hA0, 4);
    i2c_stop();
    check("part_busy", busy, 0);
    check("part_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("part_no_wr_en", wq.size(), 0);
    master_read(1'b0, 8'h00, 1);
    dq = {8'h77};
    master_write(8'h50);

    for (int t = 0; t < 8; t++) begin
      kind = $urandom_range(0, 2);
      n = $urandom_range(1, 3);
      if (kind == 0) begin
        dq = {};
        for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
        master_write(8'($urandom));
      end else begin
        master_read(kind == 1, 8'($urandom), n);
      end
    end

    mem[mptr] = 8'h00;
    i2c_start();
    write_byte(8'h53, ack); check("rst_mid_dev_ack", ack, 1);
    waited = 0;
    while (sda_oe !== 1'b1 && waited < 40) begin
      wclk(1);
      waited++;
    end
    check("rst_mid_oe_before", sda_oe, 1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_oe_released", sda_oe, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_state", 32'(dut.state_q), 32'(ST_IDLE));
    wclk(3);
    rst = 1'b0;
    rq.delete();
    mptr = 8'h00;
    i2c_stop();
    dq = {8'h9E};
    master_write(8'h05);
    master_read(1'b0, 8'h00, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/iic_target.md
IIC_TARGET -- requirements
Module: iic_target

Interface
REQ-001 Parameter DEV_ADDR, default 7'h29, 7-bit I2C target address (write address byte 8'h52, read 8'h53).
REQ-002 Parameter SYNC_STAGES, default 2, input synchronizer depth for scl and sda.
REQ-003 clk  input  1  system clock, 50 MHz.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 scl  input  1  I2C clock from the bus.
REQ-006 sda_i  input  1  I2C data as seen on the bus.
REQ-007 sda_oe  output  1  1 = drive SDA low (open-drain), 0 = release.
REQ-008 wr_en  output  1  one-cycle pulse: wr_addr/wr_data valid.
REQ-009 wr_addr  output  8  register address of the current write byte.
REQ-010 wr_data  output  8  received data byte.
REQ-011 rd_req  output  1  one-cycle pulse requesting the byte at rd_addr.
REQ-012 rd_addr  output  8  register address of the requested read byte.
REQ-013 rd_data  input  8  read byte; valid the clk cycle after rd_req.
REQ-014 busy  output  1  high from a detected START to a detected STOP.

Function
REQ-015 scl and sda_i shall pass SYNC_STAGES flops; all edges, START and STOP are detected on synchronized signals only.
REQ-016 START = sda falling while scl high; STOP = sda rising while scl high; both are valid in every state.
REQ-017 Bits shall be sampled on the synchronized scl rising edge, MSB first.
REQ-018 sda_oe shall change only on the cycle after a synchronized scl falling edge, except when released by STOP or reset.
REQ-019 States: IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-020 IDLE -> DEV_ADDR on START; STOP in any state -> IDLE, sda_oe=0, busy=0.
REQ-021 Repeated START in any state -> DEV_ADDR, bit counter cleared, register pointer kept.
REQ-022 DEV_ADDR: after 8 bits, if bits[7:1]==DEV_ADDR -> DEV_ACK, else -> IGNORE (sda_oe stays 0 until STOP or START).
REQ-023 DEV_ACK drives sda_oe=1 for the 9th clock; next state is REG_ADDR if R/W=0, else RD_DATA.
REQ-024 REG_ADDR: 8 bits load the register pointer, then REG_ACK (ACK) -> WR_DATA.
REQ-025 WR_DATA: after 8 bits, wr_en pulses once with wr_addr=pointer, wr_data=byte; WR_ACK drives ACK; pointer increments mod 256 after the pulse.
REQ-026 Read: rd_req pulses with rd_addr=pointer on the scl falling edge that ends DEV_ACK or a master-ACKed RD_ACK; rd_data is latched into the shift register on the following cycle.
REQ-027 RD_DATA: sda_oe = ~shift[7] per bit; pointer increments after each byte; sda_oe released for the 9th clock (RD_ACK).
REQ-028 RD_ACK: master ACK (sda low) -> RD_DATA with the next byte; NACK -> IGNORE until STOP or START.
REQ-029 STOP or START mid-byte discards the partial byte: no wr_en, no pointer change.

Reset
REQ-030 On rst: state=IDLE, sda_oe=0, wr_en=0, rd_req=0, busy=0, wr_addr=0, wr_data=0, rd_addr=0, pointer=0, synchronizers=1 (idle bus).
REQ-031 Reset asserted mid-transfer releases SDA within the same cycle (asynchronous); the target resumes only on a new START.

Structure
REQ-032 State encodings and default address constants go in shared package iic_defs, shared with the host side.
REQ-033 Sub-module iic_bus_sync: synchronizer, scl rise/fall strobes, START/STOP strobes.

Verification
REQ-034 START, 0x52, 0x36, 0xA5, STOP -> three ACKs (sda_oe=1 on the 9th clocks); one wr_en with wr_addr=0x36, wr_data=0xA5.
REQ-035 START, 0x52, 0x36, 0x11, 0x22, STOP -> wr_en pulses (0x36,0x11) then (0x37,0x22).
REQ-036 START, 0x54 -> no ACK; sda_oe=0 through STOP; no wr_en or rd_req.
REQ-037 START, 0x52, 0x10, Sr, 0x53; rd_data=0x5C then 0xC3; master ACK then NACK -> bus reads 0x5C, 0xC3; rd_addr 0x10, 0x11; SDA released after NACK.
REQ-038 STOP after 4 bits of a data byte -> IDLE, busy=0, no wr_en; the next transfer is normal.
REQ-039 rst asserted during RD_DATA with sda_oe=1 -> sda_oe=0 immediately, state IDLE.
